// File: rtl/npu_dram_instr_responder.sv
// Memory-side responder for the NPU DRAM and instruction-fetch ports.
// Holds a DRAM model with a fixed-latency read pipeline, and an instruction memory
// with a 1-cycle fetch path. Instruction memory can be preloaded through the load port.
module npu_dram_instr_responder #(
    parameter int DRAM_DWIDTH      = 128,
    parameter int DRAM_AWIDTH      = 10,
    parameter int INSTR_WIDTH      = 48,
    parameter int INSTR_MEM_AWIDTH = 10,
    parameter int RD_LATENCY       = 2,
    parameter int END_CHAIN_OP     = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DRAM_AWIDTH-1:0]      dram_addr,
    input  logic                        dram_write_enable,
    input  logic [DRAM_DWIDTH-1:0]      output_data_DRAM,
    output logic [DRAM_DWIDTH-1:0]      input_data_DRAM,
    output logic                        rd_valid,
    input  logic                        get_instr,
    input  logic [INSTR_MEM_AWIDTH-1:0] get_instr_addr,
    output logic [INSTR_WIDTH-1:0]      instruction,
    output logic                        instr_valid,
    input  logic                        load_en,
    input  logic [INSTR_MEM_AWIDTH-1:0] load_addr,
    input  logic [INSTR_WIDTH-1:0]      load_instr,
    output logic                        oob_fetch,
    output logic [15:0]                 wr_count,
    output logic [15:0]                 rd_count
);

    localparam int PLW = INSTR_MEM_AWIDTH + 1;
    localparam logic [INSTR_WIDTH-1:0] END_INSTR =
        {4'(END_CHAIN_OP), {(INSTR_WIDTH-4){1'b0}}};

    // Storage arrays; never reset so contents survive a reset pulse.
    logic [DRAM_DWIDTH-1:0] dram_mem [2**DRAM_AWIDTH];
    logic [INSTR_WIDTH-1:0] imem     [2**INSTR_MEM_AWIDTH];

    // Read pipeline: stage 0 captures the sample, the last stage drives the NPU.
    logic [RD_LATENCY-1:0][DRAM_DWIDTH-1:0] rd_data_q, rd_data_d;
    logic [RD_LATENCY-1:0]                  rd_vld_q, rd_vld_d;

    logic [INSTR_WIDTH-1:0] instruction_q, instruction_d;
    logic                   instr_valid_q, instr_valid_d;
    logic                   oob_fetch_q, oob_fetch_d;
    logic [PLW-1:0]         prog_len_q, prog_len_d;
    logic [15:0]            wr_count_q, wr_count_d;
    logic [15:0]            rd_count_q, rd_count_d;

    logic [PLW-1:0]         load_end;

    // Read pipeline next state: every non-write cycle launches a read; data stages
    // only load when their input is valid so the output holds between results.
    always_comb begin
        rd_vld_d     = '0;
        rd_data_d    = rd_data_q;
        rd_vld_d[0]  = ~dram_write_enable;
        if (!dram_write_enable) rd_data_d[0] = dram_mem[dram_addr];
        for (int k = 1; k < RD_LATENCY; k++) begin
            rd_vld_d[k] = rd_vld_q[k-1];
            if (rd_vld_q[k-1]) rd_data_d[k] = rd_data_q[k-1];
        end
    end

    // Saturating traffic counters.
    always_comb begin
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        if (dram_write_enable && wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
        if (!dram_write_enable && rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
    end

    // Fetch path and program length; fetch sees the pre-load memory and length.
    always_comb begin
        instruction_d = instruction_q;
        instr_valid_d = 1'b0;
        oob_fetch_d   = oob_fetch_q;
        prog_len_d    = prog_len_q;
        load_end      = PLW'(load_addr) + PLW'(1);
        if (get_instr) begin
            instr_valid_d = 1'b1;
            if (PLW'(get_instr_addr) < prog_len_q) begin
                instruction_d = imem[get_instr_addr];
            end else begin
                instruction_d = END_INSTR;
                oob_fetch_d   = 1'b1;
            end
        end
        if (load_en && load_end > prog_len_q) prog_len_d = load_end;
    end

    // Register state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_q     <= '0;
            rd_vld_q      <= '0;
            instruction_q <= '0;
            instr_valid_q <= 1'b0;
            oob_fetch_q   <= 1'b0;
            prog_len_q    <= '0;
            wr_count_q    <= '0;
            rd_count_q    <= '0;
        end else begin
            rd_data_q     <= rd_data_d;
            rd_vld_q      <= rd_vld_d;
            instruction_q <= instruction_d;
            instr_valid_q <= instr_valid_d;
            oob_fetch_q   <= oob_fetch_d;
            prog_len_q    <= prog_len_d;
            wr_count_q    <= wr_count_d;
            rd_count_q    <= rd_count_d;
        end
    end

    // Memory writes; suppressed while reset is held so reset is a quiet period.
    always_ff @(posedge clk) begin
        if (rst && dram_write_enable) dram_mem[dram_addr] <= output_data_DRAM;
        if (rst && load_en) imem[load_addr] <= load_instr;
    end

    assign input_data_DRAM = rd_data_q[RD_LATENCY-1];
    assign rd_valid        = rd_vld_q[RD_LATENCY-1];
    assign instruction     = instruction_q;
    assign instr_valid     = instr_valid_q;
    assign oob_fetch       = oob_fetch_q;
    assign wr_count        = wr_count_q;
    assign rd_count        = rd_count_q;

endmodule
